buf_uart_tx: RTL
================

Name: buf_uart_tx

Overview:
Read-side consumer for the 1k×9 dual-port buffer RAM: drains queued 9-bit words from the RAM read port and serializes each word's low 8 bits as 8N1 UART on txd. Bit 8 of each word is a frame-end marker. The block sits between the buffer RAM (port B) and the board TX pin. The CPU-side writer owns the write port and wr_ptr, and uses rd_ptr for full detection.

Parameters:
CLKS_PER_BIT, 217, clocks per serial bit (25 MHz / 115200); legal range ≥2
ADDR_W, 10, buffer address width (1024 entries)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
tx_en  in  1  allow new characters to start; current character always completes
wr_ptr  in  ADDR_W  writer's next-write index (same clock domain)
rd_addr  out  ADDR_W  RAM port B address; combinationally equal to rd_ptr
rd_data  in  9  RAM port B data; registered RAM, valid 1 clk after rd_addr
rd_ptr  out  ADDR_W  next word to read; exported to writer
txd  out  1  serial output, idle high
busy  out  1  high from LOAD through the end of STOP
frame_done  out  1  one-clock pulse at the end of STOP for a word with bit 8 = 1
empty  out  1  combinational (rd_ptr == wr_ptr)

Behaviour:
- Reset (reset_n low at clk edge): state=IDLE, rd_ptr=0, txd=1, busy=0, frame_done=0, bit counter=0, baud counter=0. Reset mid-character aborts immediately; txd=1 on the next clock. Unsent words stay in RAM, but rd_ptr=0, so the writer must also reset.
- Address: rd_addr = rd_ptr at all times. Ring buffer, no full-handling here; the writer keeps ≥1 free slot.
- Writer contract: wr_ptr advances no earlier than the clock after the RAM write commits. The read-after-write path is therefore always safe.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: if tx_en && !empty -> LOAD. rd_addr already presents rd_ptr.
  - LOAD (1 clk): capture rd_data[7:0] into shift register and rd_data[8] into frame flag. Increment rd_ptr mod 2^ADDR_W (1023 -> 0). busy=1. -> START; txd=0 registered at this edge.
  - START: txd=0 for CLKS_PER_BIT clocks -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT clocks. Bit counter 0..7 -> STOP after bit 7.
  - STOP: txd=1 for CLKS_PER_BIT clocks. On its last clock, frame_done=flag for exactly one cycle. Next state: LOAD if tx_en && !empty (skips IDLE, next start bit directly follows stop), else IDLE with busy=0.
- Baud counter: loads CLKS_PER_BIT-1 on each bit entry, decrements to 0; bit advances when 0.
- Character time: 1 + 10·CLKS_PER_BIT clocks from LOAD to next LOAD when back-to-back; +1 if via IDLE.
- tx_en deassert mid-character: character completes, then IDLE. wr_ptr changes during a character are ignored until the next decision point.
- empty is sampled only in IDLE and at the end of STOP.

Optional Feature:
BUF_UART_TX_PARITY_EN. Defined: an even-parity bit of data[7:0] is inserted between DATA bit 7 and STOP, held CLKS_PER_BIT clocks (extra PARITY state). Character time becomes 1 + 11·CLKS_PER_BIT. Undefined: plain 8N1 as above; no PARITY state exists.

Decomposition:
- Shared package holds: state enum encoding (IDLE/LOAD/START/DATA/STOP/PARITY), BUF_ADDR_W=10, BUF_WORD_W=9, FRAME_FLAG_BIT=8.
- One natural sub-module: uart_baud_tick (reloadable down-counter, CLKS_PER_BIT, outputs bit-end strobe). The pointer/FSM/shift logic stays in buf_uart_tx.

Test Plan:
- Reset, wr_ptr=0, tx_en=1 for 100 clks -> txd=1, busy=0, empty=1, rd_ptr=0.
- CPB=4. RAM[0]=0x055, wr_ptr 0->1 -> LOAD; txd sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB-first 0x55, stop), each 4 clks. rd_ptr=1, frame_done never high.
- CPB=4. RAM[1]=0x1A3, RAM[2]=0x0FF, wr_ptr=3 -> second start bit begins the clock after LOAD that follows stop #1. frame_done pulses once, 1 clk, at end of first stop only.
- rd_ptr=1023, RAM[1023]=0x041, wr_ptr=0 -> byte 0x41 sent, rd_ptr wraps to 0, empty=1, then IDLE.
- tx_en dropped during DATA bit 3 with 2 words queued -> current char completes, txd=1, busy=0, rd_ptr advanced by exactly 1. Reasserting tx_en resumes with the next word.
- reset_n low during DATA -> next clk txd=1, state IDLE, rd_ptr=0. With BUF_UART_TX_PARITY_EN, 0x07 -> parity bit=1 before stop.

Source files
------------

// File: rtl/buf_uart_tx_pkg.sv
// Shared types and constants for the buffer-draining UART transmitter.
// The optional BUF_UART_TX_PARITY_EN build adds an even-parity bit after the data bits.
package buf_uart_tx_pkg;

  localparam int BUF_ADDR_W     = 10;
  localparam int BUF_WORD_W     = 9;
  localparam int FRAME_FLAG_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_STOP   = 3'd4,
    ST_PARITY = 3'd5
  } tx_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/buf_uart_tx_baud_tick.sv
// Reloadable bit-period down-counter: bit_end marks the last clock of a bit,
// near_end the clock before it.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  output logic bit_end,
  output logic near_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = CNT_W'(CLKS_PER_BIT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end  = (cnt_q == '0);
  assign near_end = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/buf_uart_tx.sv
// Drains 9-bit words from the buffer RAM read port and sends bits [7:0] as 8N1 UART.
// Build option BUF_UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module buf_uart_tx
  import buf_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_W       = BUF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_en,
  input  logic [ADDR_W-1:0]     wr_ptr,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [BUF_WORD_W-1:0] rd_data,
  output logic [ADDR_W-1:0]     rd_ptr,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  empty,
  output tx_state_e             dbg_state
);

  // Pointer protocol: the buffer holds words [rd_ptr, wr_ptr). The writer only
  // advances wr_ptr after the RAM write has committed, and a word is consumed
  // (rd_ptr advances) in LOAD, the cycle its registered RAM data is valid.

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]        shift_q, shift_d;
  logic              flag_q, flag_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
`ifdef BUF_UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic empty_w;
  logic start_ok;
  logic baud_reload;
  logic bit_end;
  logic near_end;

  assign empty_w  = (rd_ptr_q == wr_ptr);
  assign start_ok = tx_en && !empty_w;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .reload   (baud_reload),
    .bit_end  (bit_end),
    .near_end (near_end)
  );

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    shift_d      = shift_q;
    flag_d       = flag_q;
    bit_cnt_d    = bit_cnt_q;
    txd_d        = txd_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    baud_reload  = 1'b0;
`ifdef BUF_UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        shift_d     = rd_data[7:0];
        flag_d      = rd_data[FRAME_FLAG_BIT];
`ifdef BUF_UART_TX_PARITY_EN
        par_d       = even_parity(rd_data[7:0]);
`endif
        rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
        state_d     = ST_START;
        txd_d       = 1'b0;
        baud_reload = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d     = ST_DATA;
          txd_d       = shift_q[0];
          shift_d     = shift_q >> 1;
          bit_cnt_d   = 3'd0;
          baud_reload = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_reload = 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef BUF_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = par_q;
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef BUF_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d     = ST_STOP;
          txd_d       = 1'b1;
          baud_reload = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        // Registered pulse: set one clock early so it is high on the last stop clock.
        if (near_end) begin
          frame_done_d = flag_q;
        end
        if (bit_end) begin
          if (start_ok) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= '0;
      shift_q      <= '0;
      flag_q       <= 1'b0;
      bit_cnt_q    <= '0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef BUF_UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      shift_q      <= shift_d;
      flag_q       <= flag_d;
      bit_cnt_q    <= bit_cnt_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef BUF_UART_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign rd_addr    = rd_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign empty      = empty_w;
  assign dbg_state  = state_q;

endmodule
